// File: rtl/fft_mag_buf_pkg.sv
// Shared defaults and types for the FFT magnitude/spectrum buffer.
//   FFT_N_DEF    beats per FFT frame
//   DATA_W_DEF   width of each signed re/im component
//   MAG_W_DEF    stored magnitude width
//   SHIFT_DEF    right shift applied to re^2+im^2
//   STORE_N_DEF  bins stored per frame
package fft_mag_buf_pkg;

  localparam int unsigned FFT_N_DEF   = 256;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned MAG_W_DEF   = 16;
  localparam int unsigned SHIFT_DEF   = 16;
  localparam int unsigned STORE_N_DEF = 128;

  // Frame framing state: collecting a frame, or dropping beats of a bad one.
  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

endpackage

// File: rtl/fft_mag_buf_mag_sq.sv
// Two-stage squared-magnitude pipe with a pass-through sideband.
//   Stage 1: re*re and im*im registered.
//   Stage 2: sum, right shift by SHIFT, saturate to MAG_W, registered.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_data   beat valid, {im, re} two's complement
//   in_side            opaque sideband carried alongside the beat
//   out_valid/out_mag  2-cycle delayed valid and saturated magnitude
//   out_side           sideband aligned with out_mag
module fft_mag_buf_mag_sq
  import fft_mag_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned MAG_W  = MAG_W_DEF,
  parameter int unsigned SHIFT  = SHIFT_DEF,
  parameter int unsigned SIDE_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [2*DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0]   in_side,
  output logic                out_valid,
  output logic [MAG_W-1:0]    out_mag,
  output logic [SIDE_W-1:0]   out_side
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = 2 * DATA_W + 1;
  localparam logic [SUM_W-1:0] MAG_MAX = SUM_W'({MAG_W{1'b1}});

  logic signed [DATA_W-1:0] re;
  logic signed [DATA_W-1:0] im;
  logic signed [PROD_W-1:0] re_x;
  logic signed [PROD_W-1:0] im_x;

  logic                s1_valid;
  logic [PROD_W-1:0]   re_sq;
  logic [PROD_W-1:0]   im_sq;
  logic [SIDE_W-1:0]   s1_side;

  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    shifted;

  assign re   = in_data[DATA_W-1:0];
  assign im   = in_data[2*DATA_W-1:DATA_W];
  // Sign-extend before multiplying so the square is exact.
  assign re_x = PROD_W'(re);
  assign im_x = PROD_W'(im);

  // Stage 1: squares (always non-negative, so held unsigned).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      re_sq    <= '0;
      im_sq    <= '0;
      s1_side  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        re_sq   <= $unsigned(re_x * re_x);
        im_sq   <= $unsigned(im_x * im_x);
        s1_side <= in_side;
      end
    end
  end

  // One extra bit keeps the sum full precision.
  assign sum     = {1'b0, re_sq} + {1'b0, im_sq};
  assign shifted = sum >> SHIFT;

  // Stage 2: shift and saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_side  <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mag  <= (shifted > MAG_MAX) ? {MAG_W{1'b1}} : MAG_W'(shifted);
        out_side <= s1_side;
      end
    end
  end

endmodule

// File: rtl/fft_mag_buf.sv
// FFT output magnitude buffer: squared magnitude per bin, ping-pong
// spectrum RAM for the first STORE_N bins, peak-bin tracker, and a
// registered random-access read port.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   o_axi4s_data_*       FFT output stream (no backpressure)
//   rd_addr / rd_data    display-bank read, 1-cycle latency
//   spec_valid           a good frame has been committed since reset
//   frame_done           1-cycle pulse on commit (banks swap)
//   frame_err            1-cycle pulse on a discarded malformed frame
//   peak_bin / peak_mag  peak of the last committed frame (DC excluded)
module fft_mag_buf
  import fft_mag_buf_pkg::*;
#(
  parameter int unsigned FFT_N   = FFT_N_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MAG_W   = MAG_W_DEF,
  parameter int unsigned SHIFT   = SHIFT_DEF,
  parameter int unsigned STORE_N = STORE_N_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       o_axi4s_data_tvalid,
  input  logic [2*DATA_W-1:0]        o_axi4s_data_tdata,
  input  logic                       o_axi4s_data_tlast,
  input  logic [$clog2(STORE_N)-1:0] rd_addr,
  output logic [MAG_W-1:0]           rd_data,
  output logic                       spec_valid,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [$clog2(STORE_N)-1:0] peak_bin,
  output logic [MAG_W-1:0]           peak_mag
);

  localparam int unsigned ADDR_W = $clog2(STORE_N);
  localparam int unsigned CNT_W  = $clog2(FFT_N);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FFT_N - 1);

  // Per-beat decisions travel with the data so the frame outcome lines up
  // with the write of the last beat.
  typedef struct packed {
    logic              wr_en;
    logic              commit;
    logic              err;
    logic [ADDR_W-1:0] bin;
  } side_t;

  localparam int unsigned SIDE_W = $bits(side_t);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              beat_valid;
  side_t             side_in;

  logic              s2_valid;
  logic [MAG_W-1:0]  s2_mag;
  side_t             s2_side;

  logic              wr_bank;
  logic [MAG_W-1:0]  run_max;
  logic [ADDR_W-1:0] run_bin;
  logic [MAG_W-1:0]  nxt_max;
  logic [ADDR_W-1:0] nxt_bin;

  logic [MAG_W-1:0]  mem [0:2*STORE_N-1];

  // Framing state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Framing next-state: bin counting, commit/error classification.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_valid  = 1'b0;
    side_in     = '0;
    side_in.bin = ADDR_W'(cnt_q);
    case (state_q)
      ST_COLLECT: begin
        if (o_axi4s_data_tvalid) begin
          beat_valid    = 1'b1;
          side_in.wr_en = (32'(cnt_q) < STORE_N);
          if (o_axi4s_data_tlast) begin
            cnt_d = '0;
            if (cnt_q == LAST_BEAT) side_in.commit = 1'b1;
            else                    side_in.err    = 1'b1;
          end else if (cnt_q == LAST_BEAT) begin
            // Frame ran past its length: flag it and drop the rest.
            side_in.err = 1'b1;
            cnt_d       = '0;
            state_d     = ST_DISCARD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DISCARD: begin
        if (o_axi4s_data_tvalid && o_axi4s_data_tlast) begin
          state_d = ST_COLLECT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        cnt_d   = '0;
      end
    endcase
  end

  fft_mag_buf_mag_sq #(
    .DATA_W (DATA_W),
    .MAG_W  (MAG_W),
    .SHIFT  (SHIFT),
    .SIDE_W (SIDE_W)
  ) u_mag_sq (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (beat_valid),
    .in_data   (o_axi4s_data_tdata),
    .in_side   (side_in),
    .out_valid (s2_valid),
    .out_mag   (s2_mag),
    .out_side  (s2_side)
  );

  // Running peak including the beat at the write stage; bin 0 restarts it.
  always_comb begin
    nxt_max = run_max;
    nxt_bin = run_bin;
    if (s2_valid && s2_side.wr_en) begin
      if (s2_side.bin == '0) begin
        nxt_max = '0;
        nxt_bin = '0;
      end else if (s2_mag > run_max) begin
        nxt_max = s2_mag;
        nxt_bin = s2_side.bin;
      end
    end
  end

  // Write stage: peak tracking, commit/error pulses, bank swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      spec_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      run_max    <= '0;
      run_bin    <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (s2_valid) begin
        run_max <= nxt_max;
        run_bin <= nxt_bin;
        if (s2_side.commit) begin
          frame_done <= 1'b1;
          spec_valid <= 1'b1;
          wr_bank    <= ~wr_bank;
          peak_bin   <= nxt_bin;
          peak_mag   <= nxt_max;
          run_max    <= '0;
          run_bin    <= '0;
        end
        if (s2_side.err) begin
          frame_err <= 1'b1;
          run_max   <= '0;
          run_bin   <= '0;
        end
      end
    end
  end

  // Spectrum RAM write port: only the bank being filled.
  always_ff @(posedge clk) begin
    if (s2_valid && s2_side.wr_en) begin
      mem[{wr_bank, s2_side.bin}] <= s2_mag;
    end
  end

  // Spectrum RAM read port: display bank is always the other bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[{~wr_bank, rd_addr}];
    end
  end

endmodule

// File: tb/tb_fft_mag_buf.sv
// Directed bench for fft_mag_buf: default instance plus a SHIFT=14 instance
// sharing the same stream, for the saturation case.
module tb_fft_mag_buf;

  logic        clk;
  logic        rst;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic [6:0]  rd_addr;

  logic [15:0] rd_data,  s_rd_data;
  logic        spec_valid, s_spec_valid;
  logic        frame_done, s_frame_done;
  logic        frame_err,  s_frame_err;
  logic [6:0]  peak_bin, s_peak_bin;
  logic [15:0] peak_mag, s_peak_mag;

  int checks;
  int errors;
  int done_cnt;
  int err_cnt;
  int re_arr [0:511];
  int im_arr [0:511];

  fft_mag_buf u_dut (
    .clk                 (clk),
    .rst                 (rst),
    .o_axi4s_data_tvalid (tvalid),
    .o_axi4s_data_tdata  (tdata),
    .o_axi4s_data_tlast  (tlast),
    .rd_addr             (rd_addr),
    .rd_data             (rd_data),
    .spec_valid          (spec_valid),
    .frame_done          (frame_done),
    .frame_err           (frame_err),
    .peak_bin            (peak_bin),
    .peak_mag            (peak_mag)
  );

  fft_mag_buf #(.SHIFT(14)) u_sat (
    .clk                 (clk),
    .rst                 (rst),
    .o_axi4s_data_tvalid (tvalid),
    .o_axi4s_data_tdata  (tdata),
    .o_axi4s_data_tlast  (tlast),
    .rd_addr             (rd_addr),
    .rd_data             (s_rd_data),
    .spec_valid          (s_spec_valid),
    .frame_done          (s_frame_done),
    .frame_err           (s_frame_err),
    .peak_bin            (s_peak_bin),
    .peak_mag            (s_peak_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_arr();
    for (int i = 0; i < 512; i++) begin
      re_arr[i] = 0;
      im_arr[i] = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      tdata  = '0;
    end
  endtask

  // Drives nbeats beats; tlast on beat last_idx; optional idle gap every 'gap' beats.
  task automatic send_frame(input int nbeats, input int last_idx, input int gap);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = {16'(im_arr[i]), 16'(re_arr[i])};
      tlast  = (i == last_idx);
      if (gap > 0 && (i % gap) == gap - 1) begin
        @(negedge clk);
        tvalid = 1'b0;
        tlast  = 1'b0;
      end
    end
  endtask

  task automatic read_check(input int addr, input int exp, input string tag);
    @(negedge clk);
    rd_addr = 7'(addr);
    @(negedge clk);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int d0;
    int e0;
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    err_cnt  = 0;
    rst      = 1'b1;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    tdata    = '0;
    rd_addr  = '0;
    clear_arr();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_spec_valid", 32'(spec_valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_err",  32'(frame_err), 0);
    check("rst_peak_bin",   32'(peak_bin), 0);
    check("rst_peak_mag",   32'(peak_mag), 0);
    check("rst_rd_data",    32'(rd_data), 0);
    rst = 1'b0;
    idle(2);

    // 1: tone at bin 5, with commit latency check
    clear_arr();
    re_arr[5] = 1000;
    send_frame(256, 255, 0);
    @(negedge clk); tvalid = 1'b0; tlast = 1'b0;
    check("t1_done_t1", 32'(frame_done), 0);
    @(negedge clk);
    check("t1_done_t2", 32'(frame_done), 0);
    check("t1_spec_pre", 32'(spec_valid), 0);
    @(negedge clk);
    check("t1_done_t3", 32'(frame_done), 1);
    @(negedge clk);
    check("t1_done_t4", 32'(frame_done), 0);
    check("t1_spec_valid", 32'(spec_valid), 1);
    check("t1_peak_bin", 32'(peak_bin), 5);
    check("t1_peak_mag", 32'(peak_mag), 15);
    check("t1_sat_peak_mag", 32'(s_peak_mag), 61);
    read_check(5, 15, "t1_rd5");
    read_check(4, 0, "t1_rd4");
    check("t1_done_cnt", 32'(done_cnt), 1);

    // 2: ties and DC, with tvalid gaps inside the frame
    clear_arr();
    re_arr[0] = 2000; re_arr[7] = 2000; re_arr[9] = 2000;
    send_frame(256, 255, 10);
    idle(5);
    check("t2_peak_bin", 32'(peak_bin), 7);
    check("t2_peak_mag", 32'(peak_mag), 61);
    read_check(0, 61, "t2_rd0");
    read_check(9, 61, "t2_rd9");
    read_check(5, 0, "t2_rd5");

    // 3: saturation on the SHIFT=14 instance
    clear_arr();
    re_arr[3] = -32768; im_arr[3] = -32768;
    send_frame(256, 255, 0);
    idle(5);
    check("t3_peak_bin", 32'(peak_bin), 3);
    check("t3_peak_mag", 32'(peak_mag), 32768);
    check("t3_sat_peak_bin", 32'(s_peak_bin), 3);
    check("t3_sat_peak_mag", 32'(s_peak_mag), 65535);
    read_check(3, 32768, "t3_rd3");
    check("t3_sat_rd3", 32'(s_rd_data), 65535);

    // 4: short frame
    d0 = done_cnt; e0 = err_cnt;
    clear_arr();
    re_arr[20] = 1000;
    send_frame(101, 100, 0);
    idle(6);
    check("t4_err_cnt", 32'(err_cnt - e0), 1);
    check("t4_done_cnt", 32'(done_cnt - d0), 0);
    check("t4_peak_bin", 32'(peak_bin), 3);
    read_check(3, 32768, "t4_rd3");
    read_check(20, 0, "t4_rd20");

    // 5: long frame, then a good frame including the last stored bin
    d0 = done_cnt; e0 = err_cnt;
    clear_arr();
    re_arr[10] = 1000;
    send_frame(301, 300, 0);
    idle(4);
    check("t5_err_cnt", 32'(err_cnt - e0), 1);
    check("t5_done_none", 32'(done_cnt - d0), 0);
    clear_arr();
    re_arr[11] = 1000; re_arr[127] = 2000; re_arr[128] = 4000;
    send_frame(256, 255, 0);
    idle(5);
    check("t5_done_cnt", 32'(done_cnt - d0), 1);
    check("t5_err_total", 32'(err_cnt - e0), 1);
    check("t5_peak_bin", 32'(peak_bin), 127);
    check("t5_peak_mag", 32'(peak_mag), 61);
    read_check(127, 61, "t5_rd127");
    read_check(11, 15, "t5_rd11");
    read_check(10, 0, "t5_rd10");

    // 6: back-to-back frames with gaps, then reset mid-frame
    d0 = done_cnt; e0 = err_cnt;
    clear_arr();
    re_arr[2] = 1000;
    send_frame(256, 255, 7);
    clear_arr();
    re_arr[0] = 1000; re_arr[4] = 2000;
    send_frame(256, 255, 0);
    idle(5);
    check("t6_done_cnt", 32'(done_cnt - d0), 2);
    check("t6_peak_bin", 32'(peak_bin), 4);
    check("t6_peak_mag", 32'(peak_mag), 61);
    read_check(0, 15, "t6_rd0");
    read_check(4, 61, "t6_rd4");
    read_check(2, 0, "t6_rd2");

    d0 = done_cnt; e0 = err_cnt;
    clear_arr();
    re_arr[1] = 2000;
    send_frame(50, -1, 3);
    @(negedge clk);
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_spec_valid", 32'(spec_valid), 0);
    check("t6_rst_peak_mag", 32'(peak_mag), 0);
    rst = 1'b0;
    idle(5);
    check("t6_rst_no_done", 32'(done_cnt - d0), 0);
    check("t6_rst_no_err", 32'(err_cnt - e0), 0);
    clear_arr();
    re_arr[6] = 1000;
    send_frame(256, 255, 0);
    idle(5);
    check("t6_recommit_done", 32'(done_cnt - d0), 1);
    check("t6_recommit_spec", 32'(spec_valid), 1);
    check("t6_recommit_peak_bin", 32'(peak_bin), 6);
    check("t6_recommit_peak_mag", 32'(peak_mag), 15);
    read_check(6, 15, "t6_recommit_rd6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
